// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared FSM states, opcodes, immediate formats and ALU codes
// Contents: state_t enum, OP_TYPE_* opcodes, EXT_* immediate formats,
//           WB_* write-back selects, funct7 classes and the alu_op helper.
package rv32_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    R_EXE,
    I_EXE,
    B_EXE,
    LU_EXE,
    AU_EXE,
    J_EXE,
    JL_EXE,
    S_EXE,
    S_MEM,
    L_EXE,
    L_MEM,
    L_WB,
    ILLEGAL
  } state_t;

  localparam logic [6:0] OP_TYPE_R  = 7'b0110011;
  localparam logic [6:0] OP_TYPE_I  = 7'b0010011;
  localparam logic [6:0] OP_TYPE_B  = 7'b1100011;
  localparam logic [6:0] OP_TYPE_LU = 7'b0110111;
  localparam logic [6:0] OP_TYPE_AU = 7'b0010111;
  localparam logic [6:0] OP_TYPE_J  = 7'b1101111;
  localparam logic [6:0] OP_TYPE_JL = 7'b1100111;
  localparam logic [6:0] OP_TYPE_S  = 7'b0100011;
  localparam logic [6:0] OP_TYPE_L  = 7'b0000011;

  localparam logic [2:0] EXT_I = 3'b000;
  localparam logic [2:0] EXT_S = 3'b001;
  localparam logic [2:0] EXT_B = 3'b010;
  localparam logic [2:0] EXT_U = 3'b011;
  localparam logic [2:0] EXT_J = 3'b100;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_IMM = 2'b10;
  localparam logic [1:0] WB_PC  = 2'b11;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  localparam logic [4:0] ALU_ADD = 5'b00000;

  // ALU op layout: {M-extension, alternate (funct7[5]), funct3}
  function automatic logic [4:0] alu_op(input logic mext, input logic alt,
                                        input logic [2:0] f3);
    return {mext, alt, f3};
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational ALU operation decode from instruction fields
// Ports: op[6:0], funct3[2:0], funct7[6:0] in; alu_control[4:0] out.
// Parameter EN_MEXT: nonzero decodes RV32M R-type ops onto the M-op bit.
module alu_decoder
  import rv32_pkg::*;
#(
  parameter int EN_MEXT = 0
) (
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [4:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (op)
      OP_TYPE_R: begin
        if ((EN_MEXT != 0) && (funct7 == F7_MEXT)) begin
          alu_control = alu_op(1'b1, 1'b0, funct3);
        end else begin
          alu_control = alu_op(1'b0, funct7[5], funct3);
        end
      end
      OP_TYPE_I: begin
        // Only shifts carry an arithmetic/logical selector in funct7[5];
        // for other I-type ops that bit belongs to the immediate.
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
          alu_control = alu_op(1'b0, funct7[5], funct3);
        end else begin
          alu_control = alu_op(1'b0, 1'b0, funct3);
        end
      end
      OP_TYPE_B: alu_control = alu_op(1'b0, 1'b0, funct3);
      default:   alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RV32I control FSM with retired-instruction counter
// Ports: clk, reset_n (async active-low); op, funct3, funct7 instruction fields;
//        dmem_ready memory handshake; PCEn, IREn, regFile_wr_en, AluSrcMuxSel,
//        RFWriteDataSrcMuxSel[1:0], dataMem_wr_en, dataMem_rd_en, extType[2:0],
//        Bbranch, Jbranch, JIbranch, ALUControl[4:0], illegal_instr, instret[CNT_W-1:0].
module multicycle_control_unit
  import rv32_pkg::*;
#(
  parameter int EN_MEXT  = 0,
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             dmem_ready,
  output logic             PCEn,
  output logic             IREn,
  output logic             regFile_wr_en,
  output logic             AluSrcMuxSel,
  output logic [1:0]       RFWriteDataSrcMuxSel,
  output logic             dataMem_wr_en,
  output logic             dataMem_rd_en,
  output logic [2:0]       extType,
  output logic             Bbranch,
  output logic             Jbranch,
  output logic             JIbranch,
  output logic [4:0]       ALUControl,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] instret
);

  state_t     state;
  logic [4:0] alu_control;
  logic       r_legal;
  logic       mem_done;

  alu_decoder #(.EN_MEXT(EN_MEXT)) u_alu_decoder (
    .op          (op),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_control (alu_control)
  );

  // R-type is defined only for the base, alternate and (optionally) M funct7 classes.
  assign r_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT) ||
                   ((EN_MEXT != 0) && (funct7 == F7_MEXT));

  // Without memory wait states the access phase always completes in one cycle.
  assign mem_done = (MEM_WAIT == 0) || dmem_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= FETCH;
      instret <= '0;
    end else begin
      // A skipped illegal instruction advances the PC but does not retire.
      if (PCEn && (state != ILLEGAL)) begin
        instret <= instret + CNT_W'(1);
      end
      case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          case (op)
            OP_TYPE_R:  state <= r_legal ? R_EXE : ILLEGAL;
            OP_TYPE_I:  state <= I_EXE;
            OP_TYPE_B:  state <= B_EXE;
            OP_TYPE_LU: state <= LU_EXE;
            OP_TYPE_AU: state <= AU_EXE;
            OP_TYPE_J:  state <= J_EXE;
            OP_TYPE_JL: state <= JL_EXE;
            OP_TYPE_S:  state <= S_EXE;
            OP_TYPE_L:  state <= L_EXE;
            default:    state <= ILLEGAL;
          endcase
        end
        S_EXE: state <= S_MEM;
        S_MEM: if (mem_done) state <= FETCH;
        L_EXE: state <= L_MEM;
        L_MEM: if (mem_done) state <= L_WB;
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    PCEn                 = 1'b0;
    IREn                 = 1'b0;
    regFile_wr_en        = 1'b0;
    AluSrcMuxSel         = 1'b0;
    RFWriteDataSrcMuxSel = WB_ALU;
    dataMem_wr_en        = 1'b0;
    dataMem_rd_en        = 1'b0;
    extType              = EXT_I;
    Bbranch              = 1'b0;
    Jbranch              = 1'b0;
    JIbranch             = 1'b0;
    ALUControl           = ALU_ADD;
    illegal_instr        = 1'b0;
    case (state)
      FETCH: IREn = 1'b1;
      R_EXE: begin
        PCEn          = 1'b1;
        regFile_wr_en = 1'b1;
        ALUControl    = alu_control;
      end
      I_EXE: begin
        PCEn          = 1'b1;
        regFile_wr_en = 1'b1;
        AluSrcMuxSel  = 1'b1;
        extType       = EXT_I;
        ALUControl    = alu_control;
      end
      B_EXE: begin
        PCEn       = 1'b1;
        Bbranch    = 1'b1;
        extType    = EXT_B;
        ALUControl = alu_control;
      end
      LU_EXE: begin
        PCEn                 = 1'b1;
        regFile_wr_en        = 1'b1;
        RFWriteDataSrcMuxSel = WB_IMM;
        extType              = EXT_U;
      end
      AU_EXE: begin
        PCEn                 = 1'b1;
        regFile_wr_en        = 1'b1;
        AluSrcMuxSel         = 1'b1;
        RFWriteDataSrcMuxSel = WB_PC;
        extType              = EXT_U;
      end
      J_EXE: begin
        PCEn                 = 1'b1;
        regFile_wr_en        = 1'b1;
        Jbranch              = 1'b1;
        RFWriteDataSrcMuxSel = WB_PC;
        extType              = EXT_J;
      end
      JL_EXE: begin
        PCEn                 = 1'b1;
        regFile_wr_en        = 1'b1;
        JIbranch             = 1'b1;
        AluSrcMuxSel         = 1'b1;
        RFWriteDataSrcMuxSel = WB_PC;
        extType              = EXT_I;
      end
      S_EXE: begin
        AluSrcMuxSel = 1'b1;
        extType      = EXT_S;
      end
      S_MEM: begin
        dataMem_wr_en = 1'b1;
        PCEn          = mem_done;
      end
      L_EXE: begin
        AluSrcMuxSel = 1'b1;
        extType      = EXT_I;
      end
      L_MEM: dataMem_rd_en = 1'b1;
      L_WB: begin
        PCEn                 = 1'b1;
        regFile_wr_en        = 1'b1;
        RFWriteDataSrcMuxSel = WB_MEM;
      end
      ILLEGAL: begin
        PCEn          = 1'b1;
        illegal_instr = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       pcen;
    logic       iren;
    logic       rfwe;
    logic       alusrc;
    logic [1:0] rfsel;
    logic       dmwe;
    logic       dmrd;
    logic [2:0] ext;
    logic       bb;
    logic       jb;
    logic       jib;
    logic [4:0] aluc;
    logic       ill;
  } outv_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [6:0] op, funct7;
  logic [2:0] funct3;
  logic       dmem_ready;

  logic        pcen_a, iren_a, rfwe_a, alusrc_a, dmwe_a, dmrd_a, bb_a, jb_a, jib_a, ill_a;
  logic [1:0]  rfsel_a;
  logic [2:0]  ext_a;
  logic [4:0]  aluc_a;
  logic [31:0] instret_a;
  logic        pcen_b, iren_b, rfwe_b, alusrc_b, dmwe_b, dmrd_b, bb_b, jb_b, jib_b, ill_b;
  logic [1:0]  rfsel_b;
  logic [2:0]  ext_b;
  logic [4:0]  aluc_b;
  logic [3:0]  instret_b;

  // A: M-extension on, memory wait states on, 32-bit counter.
  multicycle_control_unit #(.EN_MEXT(1), .MEM_WAIT(1), .CNT_W(32)) u_dut_a (
    .clk(clk), .reset_n(rst_a), .op(op), .funct3(funct3), .funct7(funct7),
    .dmem_ready(dmem_ready), .PCEn(pcen_a), .IREn(iren_a), .regFile_wr_en(rfwe_a),
    .AluSrcMuxSel(alusrc_a), .RFWriteDataSrcMuxSel(rfsel_a), .dataMem_wr_en(dmwe_a),
    .dataMem_rd_en(dmrd_a), .extType(ext_a), .Bbranch(bb_a), .Jbranch(jb_a),
    .JIbranch(jib_a), .ALUControl(aluc_a), .illegal_instr(ill_a), .instret(instret_a)
  );

  // B: M-extension off, no memory wait states, 4-bit counter.
  multicycle_control_unit #(.EN_MEXT(0), .MEM_WAIT(0), .CNT_W(4)) u_dut_b (
    .clk(clk), .reset_n(rst_b), .op(op), .funct3(funct3), .funct7(funct7),
    .dmem_ready(dmem_ready), .PCEn(pcen_b), .IREn(iren_b), .regFile_wr_en(rfwe_b),
    .AluSrcMuxSel(alusrc_b), .RFWriteDataSrcMuxSel(rfsel_b), .dataMem_wr_en(dmwe_b),
    .dataMem_rd_en(dmrd_b), .extType(ext_b), .Bbranch(bb_b), .Jbranch(jb_b),
    .JIbranch(jib_b), .ALUControl(aluc_b), .illegal_instr(ill_b), .instret(instret_b)
  );

  outv_t got_a, got_b;
  assign got_a = {pcen_a, iren_a, rfwe_a, alusrc_a, rfsel_a, dmwe_a, dmrd_a, ext_a,
                  bb_a, jb_a, jib_a, aluc_a, ill_a};
  assign got_b = {pcen_b, iren_b, rfwe_b, alusrc_b, rfsel_b, dmwe_b, dmrd_b, ext_b,
                  bb_b, jb_b, jib_b, aluc_b, ill_b};

  int          n_pass = 0;
  int          n_total = 0;
  int          active = 0;
  bit          chk_en = 1'b0;
  outv_t       exp_v;
  int unsigned exp_cnt = 0;
  int          ncyc_cur = 0;
  logic [4:0]  seen_aluc = '0;
  outv_t       cmp_g;
  logic [31:0] cmp_c, cmp_w;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h", name, got, want);
  endtask

  // Per-cycle compare against the model's expectation for the active instance.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_g = (active != 0) ? got_b : got_a;
      cmp_c = (active != 0) ? {28'd0, instret_b} : instret_a;
      cmp_w = (active != 0) ? (exp_cnt % 16) : exp_cnt;
      n_total++;
      if (cmp_g === exp_v) n_pass++;
      else $display("FAIL outputs t=%0t got=%h want=%h", $time, cmp_g, exp_v);
      n_total++;
      if (cmp_c === cmp_w) n_pass++;
      else $display("FAIL instret t=%0t got=%0d want=%0d", $time, cmp_c, cmp_w);
      if (exp_v.pcen) seen_aluc = cmp_g.aluc;
    end
  end

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input outv_t e, input logic rdy);
    exp_v      = e;
    dmem_ready = rdy;
    ncyc_cur++;
    @(posedge clk);
    if (e.pcen && !e.ill) exp_cnt++;
    #1;
  endtask

  // Memory access phase: waits while not ready (only when wait states exist);
  // a store finishes (PC advance) in this phase, a load does not.
  task automatic mem_phase(input outv_t e, input int stall, input bit mw);
    outv_t last;
    last      = e;
    last.pcen = e.dmwe;
    if (mw) begin
      for (int i = 0; i < stall; i++) step(e, 1'b0);
      step(last, 1'b1);
    end else begin
      step(last, 1'b0);
    end
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                           input int stall, output int ncyc);
    outv_t e;
    bit    mext, mw;
    mext = (active == 0);
    mw   = (active == 0);
    op = o; funct3 = f3; funct7 = f7;
    ncyc_cur = 0;
    e = '0; e.iren = 1'b1; step(e, rnd());
    e = '0; step(e, rnd());
    e = '0;
    case (o)
      7'b0110011: begin
        e.pcen = 1'b1;
        if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
          e.rfwe = 1'b1; e.aluc = {1'b0, f7[5], f3};
        end else if (f7 == 7'b0000001 && mext) begin
          e.rfwe = 1'b1; e.aluc = {2'b10, f3};
        end else begin
          e.ill = 1'b1;
        end
        step(e, rnd());
      end
      7'b0010011: begin
        e.pcen = 1'b1; e.rfwe = 1'b1; e.alusrc = 1'b1; e.ext = 3'd0;
        e.aluc = (f3 == 3'b001 || f3 == 3'b101) ? {1'b0, f7[5], f3} : {2'b00, f3};
        step(e, rnd());
      end
      7'b1100011: begin
        e.pcen = 1'b1; e.bb = 1'b1; e.ext = 3'd2; e.aluc = {2'b00, f3};
        step(e, rnd());
      end
      7'b0110111: begin
        e.pcen = 1'b1; e.rfwe = 1'b1; e.rfsel = 2'b10; e.ext = 3'd3;
        step(e, rnd());
      end
      7'b0010111: begin
        e.pcen = 1'b1; e.rfwe = 1'b1; e.alusrc = 1'b1; e.rfsel = 2'b11; e.ext = 3'd3;
        step(e, rnd());
      end
      7'b1101111: begin
        e.pcen = 1'b1; e.rfwe = 1'b1; e.jb = 1'b1; e.rfsel = 2'b11; e.ext = 3'd4;
        step(e, rnd());
      end
      7'b1100111: begin
        e.pcen = 1'b1; e.rfwe = 1'b1; e.jib = 1'b1; e.alusrc = 1'b1; e.rfsel = 2'b11;
        step(e, rnd());
      end
      7'b0100011: begin
        e.alusrc = 1'b1; e.ext = 3'd1; step(e, rnd());
        e = '0; e.dmwe = 1'b1; mem_phase(e, stall, mw);
      end
      7'b0000011: begin
        e.alusrc = 1'b1; step(e, rnd());
        e = '0; e.dmrd = 1'b1; mem_phase(e, stall, mw);
        e = '0; e.pcen = 1'b1; e.rfwe = 1'b1; e.rfsel = 2'b01; step(e, rnd());
      end
      default: begin
        e.pcen = 1'b1; e.ill = 1'b1; step(e, rnd());
      end
    endcase
    ncyc = ncyc_cur;
  endtask

  initial begin
    int    nc;
    outv_t fv;
    fv = '0; fv.iren = 1'b1;
    rst_a = 1'b0; rst_b = 1'b0;
    op = '0; funct3 = '0; funct7 = '0; dmem_ready = 1'b0;
    exp_v = fv; exp_cnt = 0; active = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs_a", 32'(got_a), 32'h0004_0000);
    chk("reset_instret_a", instret_a, 32'd0);
    chk_en = 1'b1;
    rst_a  = 1'b1;

    run_instr(7'b0110011, 3'b000, 7'b0000000, 0, nc);
    chk("add_latency", nc, 3);
    chk("add_instret", instret_a, 32'd1);
    run_instr(7'b0110011, 3'b000, 7'b0100000, 0, nc);
    chk("sub_aluc", seen_aluc, 5'b01000);
    run_instr(7'b0110011, 3'b000, 7'b0000001, 0, nc);
    chk("mul_aluc", seen_aluc, 5'b10000);
    run_instr(7'b0110011, 3'b000, 7'b0000011, 0, nc);
    chk("bad_f7_instret", instret_a, 32'd3);
    run_instr(7'b0010011, 3'b000, 7'b0100000, 0, nc);
    chk("addi_aluc", seen_aluc, 5'b00000);
    run_instr(7'b0010011, 3'b101, 7'b0100000, 0, nc);
    chk("srai_aluc", seen_aluc, 5'b01101);
    run_instr(7'b1100011, 3'b001, 7'b0000000, 0, nc);
    run_instr(7'b0110111, 3'b000, 7'b0000000, 0, nc);
    run_instr(7'b0010111, 3'b000, 7'b0000000, 0, nc);
    run_instr(7'b1101111, 3'b000, 7'b0000000, 0, nc);
    run_instr(7'b1100111, 3'b000, 7'b0000000, 0, nc);
    run_instr(7'b0100011, 3'b010, 7'b0000000, 2, nc);
    chk("store_stall_latency", nc, 6);
    run_instr(7'b0000011, 3'b010, 7'b0000000, 3, nc);
    chk("load_stall_latency", nc, 8);
    run_instr(7'b0000011, 3'b010, 7'b0000000, 0, nc);
    chk("load_min_latency", nc, 5);
    run_instr(7'b0100011, 3'b010, 7'b0000000, 0, nc);
    chk("store_min_latency", nc, 4);
    run_instr(7'b1111111, 3'b000, 7'b0000000, 0, nc);
    chk("illegal_latency", nc, 3);
    chk("illegal_instret", instret_a, 32'd14);

    // Reset pulse during a store stall: outputs must fall back at once.
    begin
      outv_t e;
      op = 7'b0100011; funct3 = 3'b010; funct7 = '0;
      step(fv, 1'b0);
      e = '0; step(e, 1'b0);
      e = '0; e.alusrc = 1'b1; e.ext = 3'd1; step(e, 1'b0);
      e = '0; e.dmwe = 1'b1; exp_v = e; dmem_ready = 1'b0;
      @(negedge clk);
      #2;
      rst_a = 1'b0;
      #1;
      chk("async_dmwe", dmwe_a, 32'd0);
      chk("async_iren", iren_a, 32'd1);
      chk("async_instret", instret_a, 32'd0);
      exp_cnt = 0;
      exp_v   = fv;
      @(posedge clk);
      #1;
      rst_a = 1'b1;
    end
    run_instr(7'b0110011, 3'b111, 7'b0000000, 0, nc);
    chk("after_reset_instret", instret_a, 32'd1);

    // Instance B: no M extension, no wait states, 4-bit counter.
    rst_a   = 1'b0;
    active  = 1;
    exp_cnt = 0;
    rst_b   = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      run_instr(7'b0110011, 3'(i), 7'b0000000, 0, nc);
      if (i == 15) chk("wrap_at_15", instret_b, 32'd15);
      if (i == 16) chk("wrap_to_0", instret_b, 32'd0);
    end
    chk("wrap_end", instret_b, 32'd1);
    run_instr(7'b0110011, 3'b000, 7'b0000001, 0, nc);
    chk("nomext_instret", instret_b, 32'd1);
    run_instr(7'b0100011, 3'b000, 7'b0000000, 3, nc);
    chk("nowait_store_latency", nc, 4);
    run_instr(7'b0000011, 3'b000, 7'b0000000, 3, nc);
    chk("nowait_load_latency", nc, 5);
    chk("nowait_instret", instret_b, 32'd3);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameters SHALL be (name, default, meaning): EN_MEXT, 0, decode the RV32M R-type ops; MEM_WAIT, 1, data-memory states stall on dmem_ready; CNT_W, 32, width of the retired-instruction counter.
REQ-002 Ports SHALL be (name, direction, width, meaning): clk, in, 1, sole clock, rising edge; reset_n, in, 1, asynchronous active-low reset.
REQ-003 op in 7, funct3 in 3, funct7 in 7: instruction fields, held stable by the external instruction register from DECODE until the next FETCH.
REQ-004 dmem_ready, in, 1: data memory has completed the current access.
REQ-005 PCEn, out, 1: PC register load enable.
REQ-006 IREn, out, 1: instruction register load enable.
REQ-007 regFile_wr_en, out, 1: register-file write enable.
REQ-008 AluSrcMuxSel, out, 1: ALU operand B select, 0 = rs2, 1 = imm.
REQ-009 RFWriteDataSrcMuxSel, out, 2: register-file write-data select, 00 = ALU, 01 = memory, 10 = imm, 11 = PC-relative.
REQ-010 dataMem_wr_en, out, 1: data-memory write strobe.
REQ-011 dataMem_rd_en, out, 1: data-memory read strobe.
REQ-012 extType, out, 3: immediate format, 000 = I, 001 = S, 010 = B, 011 = U, 100 = J.
REQ-013 Bbranch, Jbranch, JIbranch, out, 1 each: branch qualifiers, meaning unchanged from the single-cycle decoder.
REQ-014 ALUControl, out, 5: bit4 = M-op, bits[3:0] = {funct7[5], funct3}.
REQ-015 illegal_instr, out, 1: undefined opcode detected.
REQ-016 instret, out, CNT_W: count of retired instructions.

Function
REQ-017 The FSM SHALL have the states FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB and ILLEGAL.
REQ-018 FETCH SHALL assert IREn and always go to DECODE.
REQ-019 DECODE SHALL branch on op to the matching *_EXE state; an undefined op SHALL go to ILLEGAL.
REQ-020 Each single-step EXE state (R, I, B, LU, AU, J, JL) SHALL assert PCEn and its datapath controls, per the RV32I opcode encodings, then return to FETCH; latency is 3 cycles.
REQ-021 R_EXE and I_EXE SHALL assert regFile_wr_en together with PCEn.
REQ-022 Stores SHALL take S_EXE (address computation) and then S_MEM; S_MEM asserts dataMem_wr_en.
REQ-023 With MEM_WAIT=1, S_MEM SHALL hold until dmem_ready=1, then assert PCEn and go to FETCH; with MEM_WAIT=0 it exits after 1 cycle.
REQ-024 Loads SHALL take L_EXE, then L_MEM (dataMem_rd_en, stalls exactly as S_MEM), then L_WB, which asserts regFile_wr_en with select 01 and PCEn.
REQ-025 Minimum latency SHALL be 4 cycles for a store and 5 cycles for a load.
REQ-026 ALUControl SHALL be: R-type {0, funct7[5], funct3}; I-type shifts (funct3 001/101) {0, funct7[5], funct3}, other I-type {0, 0, funct3}; loads, stores, JL and AU add (00000); B-type {0, 0, funct3}.
REQ-027 When EN_MEXT=1 and R-type funct7=0000001, ALUControl SHALL be {1, 0, funct3}.
REQ-028 When EN_MEXT=0, R-type funct7=0000001 SHALL go to ILLEGAL.
REQ-029 An R-type funct7 other than 0000000, 0100000 or 0000001 SHALL be ILLEGAL.
REQ-030 ILLEGAL SHALL last 1 cycle, assert illegal_instr and PCEn (the instruction is skipped with no register-file or memory write), not count the instruction as retired, and go to FETCH.
REQ-031 All outputs SHALL be a combinational function of state and the decoded fields only (Moore-plus-decode); every output not used in a state SHALL be 0, with no X.
REQ-032 instret SHALL increment by 1 on each cycle where PCEn=1 and the state is not ILLEGAL, and SHALL wrap from all-ones to 0.
REQ-033 dmem_ready SHALL be ignored in every state except S_MEM and L_MEM.

Reset
REQ-034 reset_n=0 SHALL asynchronously force state FETCH and instret to 0.
REQ-035 On reset all outputs SHALL take the FETCH values (IREn=1, all others 0), including when reset arrives mid-instruction or during a memory stall.
REQ-036 The first FETCH SHALL occur on the first rising clk edge after reset_n deasserts.

Structure
REQ-037 The state enum, the opcode constants (OP_TYPE_*), the extType codes and the ALU op codes SHALL live in a shared package, rv32_pkg.
REQ-038 A single sub-module, alu_decoder, SHALL produce ALUControl combinationally from op, funct3, funct7 and EN_MEXT.

Verification
REQ-039 After reset, R-type add (op 0110011, funct7 0) -> FETCH, DECODE, R_EXE; regFile_wr_en=1 and PCEn=1 in cycle 3; instret=1.
REQ-040 Load with MEM_WAIT=1 and dmem_ready held low for 3 cycles -> L_MEM lasts 4 cycles, L_WB then asserts regFile_wr_en with select 01; total 8 cycles.
REQ-041 R-type funct7=0000001, funct3=000 -> EN_MEXT=1 gives ALUControl 10000; EN_MEXT=0 gives illegal_instr=1 and instret unchanged.
REQ-042 op=1111111 -> ILLEGAL for 1 cycle, no regFile_wr_en or dataMem_wr_en, then FETCH.
REQ-043 reset_n pulsed low during an S_MEM stall -> immediate FETCH outputs, dataMem_wr_en drops asynchronously, instret=0.
REQ-044 CNT_W=4 bench runs 17 R-type instructions -> instret wraps 15 -> 0 and ends at 1.
